speles_logika: RTL and testbench

Game-control state machine for the binary-number guessing game. Sequences a round through idle, show, guess and game-over phases from a single player button. Produces a new 5-bit target value with a load strobe for the display/compare datapath, and tracks the player's level. Sits between the button conditioning logic and the target-register/comparator block, whose equality result it consumes.

---
 rtl/speles_logika_pkg.sv | 19 +
 rtl/speles_lfsr.sv | 28 ++
 rtl/speles_logika.sv | 105 ++++++++++
 tb/tb_speles_logika.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/speles_logika_pkg.sv
// Shared definitions for the binary-number guessing game controller.
//   state_t    : phase encoding driven on the top-level state bus
//   LEVEL_MAX  : level value at which the game ends with a win streak
//   LFSR_SEED  : start value of the target generator after reset
//   LFSR_TAPS  : feedback tap mask for x^5 + x^3 + 1 (bit 4 and bit 2)
package speles_logika_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    GUESS = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam logic [7:0] LEVEL_MAX = 8'd255;
  localparam logic [4:0] LFSR_SEED = 5'b00001;
  localparam logic [4:0] LFSR_TAPS = 5'b10100;

endpackage

// File: rtl/speles_lfsr.sv
// Free-running 5-bit Fibonacci LFSR used as the target value source.
// Advances on every clock; the seed is nonzero so the all-zero lockup
// state is never entered.
//   clk    : system clock
//   rst    : asynchronous active-high reset, loads LFSR_SEED
//   lfsr_v : current LFSR contents, lfsr_v[0] is the MSB
module speles_lfsr
  import speles_logika_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [0:4] lfsr_v
);

  logic [4:0] lfsr_q;

  // Shift toward the MSB; the new LSB is the XOR of the tapped bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[3:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  assign lfsr_v = lfsr_q;

endmodule

// File: rtl/speles_logika.sv
// Game-control FSM for the binary-number guessing game.
// Sequences IDLE -> SHOW -> GUESS -> (SHOW | OVER) -> IDLE from a single
// button, issues a new target with a one-cycle load strobe on every entry
// into SHOW, and counts completed rounds in a saturating level counter.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   guess_b : debounced player button, only its rising edge acts
//   cmp_r   : 1 when the player's guess equals the current target
//   end_f   : level-sensitive end flag, forces OVER in SHOW/GUESS
//   state   : current phase (IDLE=0, SHOW=1, GUESS=2, OVER=3)
//   level   : completed-round counter, saturates at 255
//   set_f   : one-cycle strobe, target register loads set_v
//   set_v   : new target value, held between strobes
module speles_logika
  import speles_logika_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       guess_b,
  input  logic       cmp_r,
  input  logic       end_f,
  output logic [0:1] state,
  output logic [0:7] level,
  output logic       set_f,
  output logic [0:4] set_v
);

  function automatic logic [7:0] level_sat_inc(input logic [7:0] v);
    return (v == LEVEL_MAX) ? v : v + 8'd1;
  endfunction

  state_t     st_q;
  logic       guess_q;
  logic       press;
  logic [0:4] lfsr_v;
  logic [7:0] level_nxt;

  speles_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .lfsr_v (lfsr_v)
  );

  // guess_q resets high so a button held through reset release is not
  // mistaken for a fresh press.
  assign press     = guess_b & ~guess_q;
  assign level_nxt = level_sat_inc(level);
  assign state     = st_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= IDLE;
      level   <= '0;
      set_f   <= 1'b0;
      set_v   <= '0;
      guess_q <= 1'b1;
    end else begin
      guess_q <= guess_b;
      set_f   <= 1'b0;
      case (st_q)
        IDLE: begin
          if (press) begin
            st_q  <= SHOW;
            level <= '0;
            set_v <= lfsr_v;
            set_f <= 1'b1;
          end
        end
        SHOW: begin
          // end_f outranks the button in both active phases.
          if (end_f) begin
            st_q <= OVER;
          end else if (press) begin
            st_q <= GUESS;
          end
        end
        GUESS: begin
          if (end_f) begin
            st_q <= OVER;
          end else if (press) begin
            if (cmp_r) begin
              level <= level_nxt;
              if (level_nxt == LEVEL_MAX) begin
                st_q <= OVER;
              end else begin
                st_q  <= SHOW;
                set_v <= lfsr_v;
                set_f <= 1'b1;
              end
            end else begin
              st_q <= OVER;
            end
          end
        end
        OVER: begin
          if (press) begin
            st_q <= IDLE;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_speles_logika.sv
// Scoreboard bench for speles_logika: every stimulus step pushes the
// expected output snapshot; a negedge monitor pops one entry whenever the
// DUT changes phase or strobes set_f, so spurious transitions are caught.
module tb_speles_logika;

  logic       clk = 1'b0;
  logic       rst;
  logic       guess_b;
  logic       cmp_r;
  logic       end_f;
  logic [0:1] state;
  logic [0:7] level;
  logic       set_f;
  logic [0:4] set_v;

  typedef struct packed {
    logic [1:0] st;
    logic [7:0] lv;
    logic       sf;
    logic [4:0] sv;
  } exp_t;

  exp_t       sb_q[$];
  int         total = 0;
  int         bad   = 0;
  logic       mon_en = 1'b0;
  logic [1:0] prev_st = 2'd0;
  logic [4:0] m_lfsr;
  logic [7:0] e_lv;
  logic [4:0] e_sv;

  speles_logika dut (
    .clk     (clk),
    .rst     (rst),
    .guess_b (guess_b),
    .cmp_r   (cmp_r),
    .end_f   (end_f),
    .state   (state),
    .level   (level),
    .set_f   (set_f),
    .set_v   (set_v)
  );

  always #5 clk = ~clk;

  // Reference target generator: x^5 + x^3 + 1, seed 1, steps every clock.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 5'b00001;
    else     m_lfsr <= {m_lfsr[3:0], m_lfsr[4] ^ m_lfsr[2]};
  end

  // Monitor: one scoreboard entry per phase change or load strobe.
  always @(negedge clk) begin
    exp_t got;
    exp_t e;
    if (mon_en && ((state != prev_st) || set_f)) begin
      got = {state, level, set_f, set_v};
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got st=%0d lv=%0d sf=%0b sv=%b, required no event",
                 got.st, got.lv, got.sf, got.sv);
      end else begin
        e = sb_q.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL event: got st=%0d lv=%0d sf=%0b sv=%b, required st=%0d lv=%0d sf=%0b sv=%b",
                   got.st, got.lv, got.sf, got.sv, e.st, e.lv, e.sf, e.sv);
        end
      end
    end
    prev_st = state;
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic push(input logic [1:0] s, input logic [7:0] l, input logic f, input logic [4:0] v);
    sb_q.push_back({s, l, f, v});
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Rising edge held for 'hold' cycles, then one released cycle.
  task automatic press(input int hold);
    guess_b = 1'b1;
    repeat (hold) tick();
    guess_b = 1'b0;
    tick();
  endtask

  task automatic start_game();
    e_lv = 8'd0;
    e_sv = m_lfsr;
    push(2'd1, e_lv, 1'b1, e_sv);
    press(1);
  endtask

  task automatic to_guess(input int hold);
    push(2'd2, e_lv, 1'b0, e_sv);
    press(hold);
  endtask

  task automatic win();
    cmp_r = 1'b1;
    e_lv  = (e_lv == 8'd255) ? 8'd255 : e_lv + 8'd1;
    if (e_lv == 8'd255) begin
      push(2'd3, e_lv, 1'b0, e_sv);
    end else begin
      e_sv = m_lfsr;
      push(2'd1, e_lv, 1'b1, e_sv);
    end
    press(1);
    cmp_r = 1'b0;
  endtask

  task automatic lose();
    push(2'd3, e_lv, 1'b0, e_sv);
    press(1);
  endtask

  task automatic over_to_idle();
    push(2'd0, e_lv, 1'b0, e_sv);
    press(1);
  endtask

  initial begin
    rst     = 1'b1;
    guess_b = 1'b1;
    cmp_r   = 1'b0;
    end_f   = 1'b0;
    e_lv    = 8'd0;
    e_sv    = 5'd0;
    repeat (2) tick();
    chk("reset_outputs", {state, level, set_f, set_v}, 16'h0000);

    // Button held through reset release must not start a game.
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (4) tick();
    guess_b = 1'b0;
    tick();

    // First game: start, held press into GUESS, win, then lose.
    start_game();
    to_guess(10);
    win();
    to_guess(1);
    lose();
    over_to_idle();
    start_game();

    // end_f together with a winning press: OVER, no level change, no strobe.
    to_guess(1);
    push(2'd3, e_lv, 1'b0, e_sv);
    cmp_r = 1'b1;
    end_f = 1'b1;
    press(1);
    end_f = 1'b0;
    cmp_r = 1'b0;
    over_to_idle();

    // end_f ignored in IDLE.
    end_f = 1'b1;
    repeat (3) tick();
    end_f = 1'b0;

    // end_f alone in SHOW forces OVER.
    start_game();
    push(2'd3, e_lv, 1'b0, e_sv);
    end_f = 1'b1;
    tick();
    end_f = 1'b0;
    tick();
    over_to_idle();

    // Win streak to saturation.
    start_game();
    for (int i = 0; i < 255; i++) begin
      to_guess(1);
      win();
    end
    chk("level_saturated", {8'd0, level}, 16'h00ff);
    over_to_idle();
    start_game();

    // Asynchronous reset mid-GUESS with the button held.
    to_guess(1);
    win();
    push(2'd2, e_lv, 1'b0, e_sv);
    guess_b = 1'b1;
    tick();
    push(2'd0, 8'd0, 1'b0, 5'd0);
    rst = 1'b1;
    #1;
    chk("async_reset", {state, level, set_f, set_v}, 16'h0000);
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("held_after_reset", {14'd0, state}, 16'h0000);
    guess_b = 1'b0;
    tick();
    start_game();
    to_guess(1);

    repeat (4) tick();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL pending_events: got %0d outstanding, required 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
